// File: rtl/gp_axis_pingpong_interface.sv
// AXI-Stream <-> accelerator-wrapper bridge with a ping-pong input buffer.
// Ports: clk/rst; s_* AXIS slave; m_* AXIS master; axisif_* wrapper side;
//        err_last sticky framing error, err_clr synchronous clear.
module gp_axis_pingpong_interface #(
    parameter int DATA_WIDTH    = 32,
    parameter int IN_DATA_NUM   = 8,
    parameter int OUT_DATA_NUM  = 4,
    parameter int IN_ADR_WIDTH  = 3,
    parameter int OUT_ADR_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    s_data,
    input  logic                     s_valid,
    input  logic                     s_last,
    output logic                     s_ready,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     m_valid,
    output logic                     m_last,
    input  logic                     m_ready,
    output logic                     axisif_start,
    input  logic                     axisif_done,
    output logic                     axisif_bank,
    input  logic [IN_ADR_WIDTH-1:0]  axisif_bufferIn_adr,
    output logic [DATA_WIDTH-1:0]    axisif_bufferIn_data,
    input  logic [OUT_ADR_WIDTH-1:0] axisif_bufferOut_adr,
    input  logic [DATA_WIDTH-1:0]    axisif_bufferOut_data,
    input  logic                     axisif_bufferOut_wr,
    output logic                     err_last,
    input  logic                     err_clr
);

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_START = 2'd1;
    localparam logic [1:0] C_WLOW  = 2'd2;
    localparam logic [1:0] C_WHIGH = 2'd3;

    localparam logic [IN_ADR_WIDTH-1:0] IN_LAST =
        IN_ADR_WIDTH'(IN_DATA_NUM - 1);
    localparam logic [OUT_ADR_WIDTH-1:0] OUT_LAST =
        OUT_ADR_WIDTH'(OUT_DATA_NUM - 1);

    logic [DATA_WIDTH-1:0] ibuf [2][IN_DATA_NUM];
    logic [DATA_WIDTH-1:0] obuf [OUT_DATA_NUM];

    logic [1:0]              full;
    logic [1:0]              full_nxt;
    logic                    wr_bank;
    logic                    rd_bank;
    logic [IN_ADR_WIDTH-1:0] in_cnt;

    logic [1:0]               core_st;
    logic                     out_busy;
    logic [OUT_ADR_WIDTH-1:0] ocnt;

    logic s_fire;
    logic in_end;
    logic frame_err;
    logic release_bank;

    // Gated by rst so the slave sees not-ready while reset is held.
    assign s_ready   = !rst && !full[wr_bank];
    assign s_fire    = s_valid && s_ready;
    assign in_end    = s_fire && (in_cnt == IN_LAST);
    assign frame_err = s_fire && (s_last != (in_cnt == IN_LAST));

    // Wrapper has gone busy and come back idle: its bank is consumed.
    assign release_bank = (core_st == C_WHIGH) && axisif_done;

    assign axisif_start = (core_st == C_START);
    assign axisif_bank  = rd_bank;
    assign axisif_bufferIn_data = ibuf[rd_bank][axisif_bufferIn_adr];

    assign m_valid = out_busy;
    assign m_data  = out_busy ? obuf[ocnt] : '0;
    assign m_last  = out_busy && (ocnt == OUT_LAST);

    // Storage carries no reset; contents are only meaningful once filled.
    always_ff @(posedge clk) begin
        if (s_fire) begin
            ibuf[wr_bank][in_cnt] <= s_data;
        end
        if (axisif_bufferOut_wr) begin
            obuf[axisif_bufferOut_adr] <= axisif_bufferOut_data;
        end
    end

    // Release and fill always target different banks, so both apply.
    always_comb begin
        full_nxt = full;
        if (release_bank) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (in_end) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            in_cnt  <= '0;
        end else begin
            full <= full_nxt;
            if (s_fire) begin
                if (in_cnt == IN_LAST) begin
                    in_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    in_cnt <= in_cnt + 1'b1;
                end
            end
        end
    end

    // A new framing error takes priority over a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_last <= 1'b0;
        end else if (frame_err) begin
            err_last <= 1'b1;
        end else if (err_clr) begin
            err_last <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_st <= C_IDLE;
            rd_bank <= 1'b0;
        end else begin
            unique case (core_st)
                C_IDLE: begin
                    // Hold off while results are still streaming out,
                    // otherwise the wrapper would overwrite them.
                    if (full[rd_bank] && !out_busy) begin
                        core_st <= C_START;
                    end
                end
                C_START: begin
                    core_st <= C_WLOW;
                end
                C_WLOW: begin
                    if (!axisif_done) begin
                        core_st <= C_WHIGH;
                    end
                end
                C_WHIGH: begin
                    if (axisif_done) begin
                        core_st <= C_IDLE;
                        rd_bank <= ~rd_bank;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_busy <= 1'b0;
            ocnt     <= '0;
        end else if (!out_busy) begin
            if (release_bank) begin
                out_busy <= 1'b1;
                ocnt     <= '0;
            end
        end else if (m_ready) begin
            if (ocnt == OUT_LAST) begin
                out_busy <= 1'b0;
                ocnt     <= '0;
            end else begin
                ocnt <= ocnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gp_axis_pingpong_interface.sv
// Bench for gp_axis_pingpong_interface: packet-level model plus a
// behavioural wrapper that answers each start with result[j] = in[j] + 1.
module tb_gp_axis_pingpong_interface;

    localparam int DW   = 32;
    localparam int IN_N = 8;
    localparam int OUTN = 4;
    localparam int IAW  = 3;
    localparam int OAW  = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [DW-1:0]  s_data = '0;
    logic           s_valid = 1'b0;
    logic           s_last = 1'b0;
    logic           s_ready;
    logic [DW-1:0]  m_data;
    logic           m_valid;
    logic           m_last;
    logic           m_ready = 1'b1;
    logic           axisif_start;
    logic           axisif_done = 1'b1;
    logic           axisif_bank;
    logic [IAW-1:0] in_adr = '0;
    logic [DW-1:0]  in_data;
    logic [OAW-1:0] out_adr = '0;
    logic [DW-1:0]  out_data = '0;
    logic           out_wr = 1'b0;
    logic           err_last;
    logic           err_clr = 1'b0;

    gp_axis_pingpong_interface #(
        .DATA_WIDTH(DW), .IN_DATA_NUM(IN_N), .OUT_DATA_NUM(OUTN),
        .IN_ADR_WIDTH(IAW), .OUT_ADR_WIDTH(OAW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready),
        .axisif_start(axisif_start), .axisif_done(axisif_done),
        .axisif_bank(axisif_bank),
        .axisif_bufferIn_adr(in_adr), .axisif_bufferIn_data(in_data),
        .axisif_bufferOut_adr(out_adr), .axisif_bufferOut_data(out_data),
        .axisif_bufferOut_wr(out_wr),
        .err_last(err_last), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [DW-1:0] cur_q[$];
    logic [DW-1:0] words_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mlog[$];
    bit  m_err = 0;
    bit  busy = 0;
    bit  rd_exp = 0;
    bit  prev_done = 1;
    int  starts = 0;
    int  completed = 0;
    int  sent_full = 0;

    // Stimulus knobs
    int mmode = 0;
    int clr_mode = 0;
    int wr_hold = 3;
    bit hold_rand = 0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic check_seq(input string nm, input int first);
        for (int k = 0; k < OUTN; k++) begin
            if (k < mlog.size()) check(nm, mlog[k], DW'(first + k));
        end
        for (int k = 0; k < OUTN; k++) begin
            if (mlog.size() > 0) void'(mlog.pop_front());
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (mmode)
            0: m_ready = 1'b1;
            1: m_ready = ~m_ready;
            2: m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    end

    always @(posedge clk) begin
        #2;
        case (clr_mode)
            1: err_clr = 1'b1;
            2: err_clr = ($urandom_range(0, 7) == 0);
            default: err_clr = 1'b0;
        endcase
    end

    // Monitor: compare against the model, then apply the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_s_ready", s_ready, 0);
            check("rst_m_valid", m_valid, 0);
            check("rst_start", axisif_start, 0);
            check("rst_err", err_last, 0);
            check("rst_bank", axisif_bank, 0);
            cur_q.delete();
            words_q.delete();
            exp_q.delete();
            m_err = 0;
            busy = 0;
            rd_exp = 0;
        end else begin
            check("s_ready", s_ready, words_q.size() < 2 * IN_N);
            check("m_valid", m_valid, exp_q.size() != 0);
            check("err_last", err_last, m_err);
            if (m_valid && exp_q.size() != 0) begin
                check("m_data", m_data, exp_q[0]);
                check("m_last", m_last, exp_q.size() == 1);
                if (m_ready) begin
                    mlog.push_back(m_data);
                    void'(exp_q.pop_front());
                end
            end
            if (axisif_start) begin
                check("start_legal",
                      !busy && words_q.size() != 0 && exp_q.size() == 0, 1);
                check("start_bank", axisif_bank, rd_exp);
                busy = 1;
                starts++;
            end
            if (s_valid && s_ready) begin
                cur_q.push_back(s_data);
                if (s_last != (cur_q.size() == IN_N)) m_err = 1;
                else if (err_clr) m_err = 0;
                if (cur_q.size() == IN_N) begin
                    foreach (cur_q[k]) words_q.push_back(cur_q[k]);
                    cur_q.delete();
                    completed++;
                end
            end else if (err_clr) begin
                m_err = 0;
            end
            if (busy && axisif_done && !prev_done) begin
                for (int j = 0; j < OUTN; j++) begin
                    exp_q.push_back(words_q[j] + 1);
                end
                for (int j = 0; j < IN_N; j++) void'(words_q.pop_front());
                busy = 0;
                rd_exp = ~rd_exp;
            end
        end
        prev_done = axisif_done;
    end

    // Behavioural wrapper
    initial begin : wrapper
        logic [DW-1:0] rd;
        int hold;
        forever begin
            @(negedge clk);
            if (axisif_start && !rst) begin
                hold = hold_rand ? int'($urandom_range(0, 5)) : wr_hold;
                @(posedge clk);
                #1;
                axisif_done = 1'b0;
                in_adr = '0;
                for (int i = 0; i < IN_N; i++) begin
                    @(negedge clk);
                    rd = in_data;
                    if (words_q.size() > i) check("bufin", rd, words_q[i]);
                    @(posedge clk);
                    #1;
                    in_adr = IAW'(i + 1);
                    if (i < OUTN) begin
                        out_adr  = OAW'(i);
                        out_data = rd + 1;
                        out_wr   = 1'b1;
                    end else begin
                        out_wr = 1'b0;
                    end
                end
                repeat (hold) @(posedge clk);
                #1;
                axisif_done = 1'b1;
            end
        end
    end

    // first < 0 selects random data; last_at < 0 never raises s_last.
    task automatic send_pkt(input int first, input int last_at,
                            input int nbeats, input int gap);
        bit ok;
        int n;
        @(posedge clk);
        #1;
        for (int i = 0; i < nbeats; i++) begin
            s_valid = 1'b1;
            s_data  = (first < 0) ? DW'($urandom) : DW'(first + i);
            s_last  = (i == last_at);
            n = 0;
            do begin
                @(negedge clk);
                ok = s_ready;
                @(posedge clk);
                #1;
                n++;
            end while (!ok && n < 400);
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (!ok) begin
                check("s_timeout", ok, 1);
                break;
            end
            if (gap > 0) begin
                repeat ($urandom_range(0, gap)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        if (nbeats == IN_N) sent_full++;
    endtask

    task automatic wait_idle(input string nm);
        bit idle = 0;
        for (int n = 0; n < 3000 && !idle; n++) begin
            @(negedge clk);
            idle = words_q.size() == 0 && cur_q.size() == 0 &&
                   exp_q.size() == 0 && !busy && axisif_done;
        end
        check(nm, idle, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin : main
        int st0;
        int len;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t1_ready", s_ready, 1);

        // 1: single packet
        mlog.delete();
        send_pkt(1, IN_N - 1, IN_N, 0);
        wait_idle("t1_idle");
        check("t1_starts", starts, 1);
        len = mlog.size();
        check("t1_len", len, 4);
        check_seq("t1_seq", 2);

        // 2: long compute, second bank fills, third packet stalls
        wr_hold = 50;
        send_pkt(-1, IN_N - 1, IN_N, 0);
        send_pkt(-1, IN_N - 1, IN_N, 0);
        @(negedge clk);
        check("t2_stall", s_ready, 0);
        send_pkt(-1, IN_N - 1, IN_N, 0);
        wait_idle("t2_idle");
        wr_hold = 3;

        // 3: m_ready toggling
        mlog.delete();
        mmode = 1;
        send_pkt(1, IN_N - 1, IN_N, 0);
        wait_idle("t3_idle");
        mmode = 0;
        len = mlog.size();
        check("t3_len", len, 4);
        check_seq("t3_seq", 2);

        // 4: early s_last, then clear
        mlog.delete();
        send_pkt(1, 2, IN_N, 0);
        @(negedge clk);
        check("t4_err_set", err_last, 1);
        @(posedge clk);
        #1;
        clr_mode = 1;
        @(posedge clk);
        #1;
        clr_mode = 0;
        @(negedge clk);
        check("t4_err_clr", err_last, 0);
        wait_idle("t4_idle");
        check_seq("t4_seq", 2);

        // 5: reset mid-packet
        mlog.delete();
        send_pkt(100, -1, 5, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_ready", s_ready, 1);
        send_pkt(1, IN_N - 1, IN_N, 0);
        wait_idle("t5_idle");
        len = mlog.size();
        check("t5_len", len, 4);
        check_seq("t5_seq", 2);

        // 6: start held off while output is stalled
        mlog.delete();
        mmode = 3;
        send_pkt(1, IN_N - 1, IN_N, 0);
        for (int n = 0; n < 200 && !m_valid; n++) @(negedge clk);
        check("t6_valid", m_valid, 1);
        st0 = starts;
        send_pkt(11, IN_N - 1, IN_N, 0);
        repeat (30) @(negedge clk);
        check("t6_no_start", starts, st0);
        check("t6_held", m_valid, 1);
        mmode = 0;
        wait_idle("t6_idle");
        check("t6_one_start", starts, st0 + 1);
        len = mlog.size();
        check("t6_len", len, 8);
        check_seq("t6_seq_a", 2);
        check_seq("t6_seq_b", 12);

        // Random traffic
        mmode = 2;
        clr_mode = 2;
        hold_rand = 1;
        for (int p = 0; p < 20; p++) begin
            int la;
            int r;
            r = int'($urandom_range(0, 9));
            la = IN_N - 1;
            if (r == 0) la = int'($urandom_range(0, IN_N - 2));
            else if (r == 1) la = -1;
            send_pkt(-1, la, IN_N, 3);
        end
        wait_idle("rnd_idle");
        mmode = 0;
        clr_mode = 0;

        check("final_completed", completed, sent_full);
        check("final_starts", starts, sent_full);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
